// File: rtl/ireq_hello_packer.sv
// Packs a user write stream into SRIO HELLO-format ireq packets: one header beat
// built from the latched first-beat fields, then a length-exact payload pass-through.
module ireq_hello_packer #(
  parameter logic [15:0] SRC_ID  = 16'h00F0,
  parameter logic [15:0] DEST_ID = 16'h00FF,
  parameter logic [1:0]  PRIO    = 2'b01,
  parameter logic        CRF     = 1'b0
) (
  input  logic        log_clk,
  input  logic        log_rst,
  input  logic [33:0] user_addr_in,
  input  logic [3:0]  user_ftype_in,
  input  logic [3:0]  user_ttype_in,
  input  logic [11:0] user_tsize_in,
  input  logic [63:0] user_tdata_in,
  input  logic        user_tvalid_in,
  input  logic        user_tlast_in,
  output logic        user_tready_o,
  output logic        nwr_ready_o,
  output logic        nwr_busy_o,
  output logic [63:0] ireq_tdata_o,
  output logic        ireq_tvalid_o,
  output logic        ireq_tlast_o,
  output logic [7:0]  ireq_tkeep_o,
  output logic [31:0] ireq_tuser_o,
  input  logic        ireq_tready_in,
  output logic        len_err_o,
  output logic        size_err_o,
  output logic        type_err_o,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both
  // high; valid never waits on ready, and a presented header holds until taken.
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [33:0] addr_q;
  logic [3:0]  ftype_q;
  logic [3:0]  ttype_q;
  logic [7:0]  tsize_q;
  logic [7:0]  tid_q;
  logic [4:0]  beat_cnt_q;
  logic        size_bad;
  logic        type_bad;
  logic        last_beat;
  logic        data_hs;
  logic [63:0] hdr;

  assign size_bad  = (user_tsize_in[11:8] != 4'd0);
  assign type_bad  = (user_ftype_in != 4'd5) && (user_ftype_in != 4'd6);
  // Beat count is tsize[7:3]+1, so the final beat index equals tsize[7:3].
  assign last_beat = (beat_cnt_q == tsize_q[7:3]);
  assign data_hs   = user_tvalid_in && ireq_tready_in;
  assign hdr       = {tid_q, ftype_q, ttype_q, 1'b0, PRIO, CRF, tsize_q, 2'b00, addr_q};

  assign ireq_tkeep_o = 8'hFF;
  assign ireq_tuser_o = {SRC_ID, DEST_ID};
  assign nwr_ready_o  = (state_q == S_IDLE);
  assign nwr_busy_o   = (state_q != S_IDLE);
  assign dbg_state_o  = state_q;

  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    user_tready_o = 1'b0;
    ireq_tvalid_o = 1'b0;
    ireq_tlast_o  = 1'b0;
    ireq_tdata_o  = hdr;
    case (state_q)
      S_IDLE: begin
        if (user_tvalid_in) begin
          if (size_bad || type_bad) state_d = S_DROP;
          else                      state_d = S_HDR;
        end
      end
      S_HDR: begin
        ireq_tvalid_o = 1'b1;
        if (ireq_tready_in) state_d = S_DATA;
      end
      S_DATA: begin
        ireq_tdata_o  = user_tdata_in;
        ireq_tvalid_o = user_tvalid_in;
        ireq_tlast_o  = last_beat;
        user_tready_o = ireq_tready_in;
        if (data_hs && last_beat) state_d = S_IDLE;
      end
      S_DROP: begin
        user_tready_o = 1'b1;
        if (user_tvalid_in && user_tlast_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      addr_q     <= '0;
      ftype_q    <= '0;
      ttype_q    <= '0;
      tsize_q    <= '0;
      tid_q      <= '0;
      beat_cnt_q <= '0;
      len_err_o  <= 1'b0;
      size_err_o <= 1'b0;
      type_err_o <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (user_tvalid_in) begin
            addr_q  <= user_addr_in;
            ftype_q <= user_ftype_in;
            ttype_q <= user_ttype_in;
            tsize_q <= user_tsize_in[7:0];
            if (size_bad)      size_err_o <= 1'b1;
            else if (type_bad) type_err_o <= 1'b1;
          end
        end
        S_HDR: begin
          if (ireq_tready_in) beat_cnt_q <= '0;
        end
        S_DATA: begin
          if (data_hs) begin
            // Upstream tlast must coincide exactly with the header-declared last beat.
            if (last_beat != user_tlast_in) len_err_o <= 1'b1;
            if (last_beat) tid_q <= tid_q + 8'd1;
            else           beat_cnt_q <= beat_cnt_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
